hex_uart_streamer: RTL and testbench
====================================

HEX_UART_STREAMER -- requirements
Module: hex_uart_streamer

Interface
REQ-001 Parameter DATA_W, default 32: input word width; SHALL be a multiple of 4, range 8..64.
REQ-002 Parameter FIFO_DEPTH, default 8: words buffered; SHALL be a power of two, at least 2.
REQ-003 Parameter ONCHANGE, default 1: 1 = enqueue only on value change; 0 = enqueue every valid word.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rstn  input  1  asynchronous, active-low reset.
REQ-006 din  input  DATA_W  word to print as hex.
REQ-007 din_valid  input  1  din qualifier.
REQ-008 din_ready  output  1  high when FIFO not full.
REQ-009 tstart  output  1  one-cycle start pulse to byte transmitter.
REQ-010 tbus  output  8  ASCII byte, valid while tstart high.
REQ-011 tready  input  1  byte transmitter idle.
REQ-012 busy  output  1  high while FIFO non-empty or FSM not IDLE.
REQ-013 ovf  output  1  sticky; set when din_valid is high with the FIFO full and the word is not a suppressed duplicate.

Function
REQ-014 Write: din_valid && din_ready enqueues din, subject to REQ-015; when full, the word SHALL be dropped.
REQ-015 ONCHANGE=1: enqueue only if din differs from the last enqueued word; the first word after reset is always enqueued.
REQ-016 Each word SHALL emit DATA_W/4 characters, most-significant nibble first, as uppercase ASCII: 0-9 = 0x30-0x39, A-F = 0x41-0x46; the terminator follows (REQ-024).
REQ-017 FSM states: IDLE, LOAD, SEND, WAIT, TERM, TERM_WAIT.
REQ-018 IDLE->LOAD when the FIFO is non-empty; LOAD pops one word into a shift register and clears the nibble counter in one cycle, then goes to SEND.
REQ-019 SEND: when tready=1, pulse tstart for exactly one cycle with tbus = current character, then go to WAIT; if tready=0, hold in SEND.
REQ-020 WAIT: ignore tready for the cycle after tstart; then on tready=1, advance the nibble; go to TERM after the last nibble, else back to SEND.
REQ-021 TERM/TERM_WAIT emit the terminator byte(s) using the same handshake, then go to IDLE, or to LOAD if the FIFO is non-empty (no idle cycle).
REQ-022 tstart SHALL never assert while tready=0; tbus SHALL be stable from tstart until the next tstart.
REQ-023 Simultaneous push and pop on a full FIFO: the pop SHALL free space before the push is checked, so the word is accepted. Pointers wrap modulo FIFO_DEPTH.

Configuration
REQ-024 Macro HEX_STREAM_CRLF_EN defined: the terminator is 0x0D then 0x0A. Undefined: the terminator is a single 0x20.

Reset
REQ-025 rstn low: tstart=0, tbus=0x00, ovf=0, busy=0, FIFO empty, FSM=IDLE, last-word register cleared, first-word flag set; din_ready=1 at the first edge after release.
REQ-026 Reset during a word SHALL abort it; no further tstart and no partial resume after release.

Structure
REQ-027 Package hex_stream_pkg SHALL hold the FSM state enum, the ASCII constants (CR, LF, SPACE) and the nibble-to-ASCII function.
REQ-028 The FIFO SHALL be a sub-module sync_fifo (parameters WIDTH, DEPTH; ports push, pop, full, empty); the streamer holds the FSM, the change detector and the output registers.

Verification
REQ-029 DATA_W=16 with CRLF defined: din=0xA5F0, tready held 1 -> tbus sequence 0x41,0x35,0x46,0x30,0x0D,0x0A; exactly 6 tstart pulses; busy falls after the last one.
REQ-030 ONCHANGE=1: din=0x1234 valid for 10 cycles, then 0x1235 -> exactly two words printed.
REQ-031 FIFO_DEPTH=4, tready=0: push 5 distinct words -> din_ready=0 after the 4th, 5th dropped, ovf=1; with tready=1 exactly 4 words print in order.
REQ-032 tready toggling (low 20 cycles after each tstart): no tstart while tready=0; byte order unchanged.
REQ-033 rstn low after the 2nd character: tstart and busy = 0 at once; after release, a new din=0x00FF prints as the full "00FF" plus terminator.
REQ-034 Macro undefined, DATA_W=8: din=0x9C -> 0x39,0x43,0x20.

Source files
------------

// File: rtl/hex_stream_pkg.sv
// Shared types and helpers for the hex streamer: FSM state encoding,
// terminator characters and the nibble-to-ASCII conversion.
package hex_stream_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT,
    TERM,
    TERM_WAIT
  } state_t;

  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] SPACE = 8'h20;

  // Uppercase hex digit: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46
  function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; a pop in the same cycle frees room for a push,
// so a push into a full FIFO is accepted when a pop happens alongside it.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head word is visible before the pop so the consumer can load it in the pop cycle
  assign rdata   = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wdata;
  end

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/hex_uart_streamer.sv
// Buffers input words and prints each as uppercase hex to a byte transmitter.
// Define HEX_STREAM_CRLF_EN for a CR LF terminator; otherwise one space follows each word.
module hex_uart_streamer
  import hex_stream_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int ONCHANGE   = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              tstart,
  output logic [7:0]        tbus,
  input  logic              tready,
  output logic              busy,
  output logic              ovf
);

  localparam int NIBBLES = DATA_W / 4;
  localparam int CNT_W   = $clog2(NIBBLES);
`ifdef HEX_STREAM_CRLF_EN
  localparam bit TERM_TWO = 1'b1;
`else
  localparam bit TERM_TWO = 1'b0;
`endif

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] last_reg;
  logic [DATA_W-1:0] fifo_rdata;
  logic [CNT_W-1:0]  nib_cnt_reg;
  logic              term_idx_reg;
  logic              skip_reg;
  logic              first_reg;
  logic              ovf_reg;
  logic [7:0]        tbus_reg;
  logic [7:0]        char_now;
  logic [7:0]        term_char;
  logic              fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic              dup, last_nib, term_done;

  assign dup       = (ONCHANGE != 0) && !first_reg && (din == last_reg);
  assign fifo_push = din_valid && !dup;
  assign din_ready = !fifo_full || fifo_pop;
  assign ovf       = ovf_reg;
  assign last_nib  = (nib_cnt_reg == CNT_W'(NIBBLES - 1));
  assign term_done = !TERM_TWO || term_idx_reg;
  assign term_char = TERM_TWO ? (term_idx_reg ? LF : CR) : SPACE;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (fifo_push),
    .wdata (din),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // skip_reg is high in the cycle right after tstart, when tready is not yet meaningful
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (!fifo_empty) state_next = LOAD;
      LOAD:      state_next = SEND;
      SEND:      if (tready) state_next = WAIT;
      WAIT:      if (!skip_reg && tready) state_next = last_nib ? TERM : SEND;
      TERM:      if (tready) state_next = TERM_WAIT;
      TERM_WAIT: begin
        if (!skip_reg && tready) begin
          if (!term_done)       state_next = TERM;
          else if (!fifo_empty) state_next = LOAD;
          else                  state_next = IDLE;
        end
      end
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    tstart   = 1'b0;
    fifo_pop = 1'b0;
    char_now = term_char;
    case (state_reg)
      LOAD: fifo_pop = 1'b1;
      SEND: begin
        tstart   = tready;
        char_now = nib2ascii(shift_reg[DATA_W-1 -: 4]);
      end
      TERM: tstart = tready;
      default: ;
    endcase
    // New byte appears together with tstart and then holds until the next one
    tbus = tstart ? char_now : tbus_reg;
    busy = !fifo_empty || (state_reg != IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift_reg    <= '0;
      nib_cnt_reg  <= '0;
      term_idx_reg <= 1'b0;
      skip_reg     <= 1'b0;
      tbus_reg     <= 8'h00;
      last_reg     <= '0;
      first_reg    <= 1'b1;
      ovf_reg      <= 1'b0;
    end else begin
      skip_reg <= tstart;
      tbus_reg <= tbus;
      if (fifo_pop) begin
        shift_reg    <= fifo_rdata;
        nib_cnt_reg  <= '0;
        term_idx_reg <= 1'b0;
      end else if (state_reg == WAIT && state_next != WAIT) begin
        shift_reg   <= shift_reg << 4;
        nib_cnt_reg <= nib_cnt_reg + 1'b1;
      end
      if (state_reg == TERM_WAIT && state_next == TERM) term_idx_reg <= 1'b1;
      if (fifo_push && din_ready) begin
        last_reg  <= din;
        first_reg <= 1'b0;
      end
      if (fifo_push && !din_ready) ovf_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hex_uart_streamer.sv
// Directed bench for hex_uart_streamer: a 16-bit on-change instance with a
// 4-deep FIFO and an 8-bit every-word instance with a 2-deep FIFO.
module tb_hex_uart_streamer;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] din = 16'h0000;
  logic        din_valid = 1'b0;
  logic        din_ready, tstart, busy, ovf;
  logic [7:0]  tbus;
  logic        tready;
  logic        tready_man = 1'b1;
  logic        tr_auto = 1'b0;
  logic        auto_rdy = 1'b1;
  assign tready = tr_auto ? auto_rdy : tready_man;

  logic [7:0]  b_din = 8'h00;
  logic        b_valid = 1'b0;
  logic        b_ready, b_tstart, b_busy, b_ovf;
  logic [7:0]  b_tbus;
  logic        b_tready = 1'b1;

  hex_uart_streamer #(.DATA_W(16), .FIFO_DEPTH(4), .ONCHANGE(1)) dut (
    .clk(clk), .rstn(rstn), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .tstart(tstart), .tbus(tbus), .tready(tready), .busy(busy), .ovf(ovf)
  );

  hex_uart_streamer #(.DATA_W(8), .FIFO_DEPTH(2), .ONCHANGE(0)) dut_b (
    .clk(clk), .rstn(rstn), .din(b_din), .din_valid(b_valid), .din_ready(b_ready),
    .tstart(b_tstart), .tbus(b_tbus), .tready(b_tready), .busy(b_busy), .ovf(b_ovf)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] got[$];
  logic [7:0] got_b[$];
  logic [7:0] exp_q[$];
  int         hold = 0;
  logic [7:0] last_tbus = 8'h00;

  // Byte capture plus handshake and tbus-hold checks on every cycle
  always @(negedge clk) begin
    if (!rstn) begin
      last_tbus = 8'h00;
    end else if (tstart) begin
      got.push_back(tbus);
      checks++;
      if (!tready) begin
        errors++;
        $display("FAIL tstart_vs_tready: tstart=1 while tready=%b, required tready=1", tready);
      end
      last_tbus = tbus;
      if (tr_auto) hold = 20;
    end else begin
      checks++;
      if (tbus !== last_tbus) begin
        errors++;
        $display("FAIL tbus_hold: tbus=%h between pulses, required %h", tbus, last_tbus);
      end
      if (hold > 0) hold--;
    end
    if (b_tstart) got_b.push_back(b_tbus);
  end

  // Emulated transmitter: busy for 20 cycles after each start when tr_auto is set
  always @(posedge clk) begin
    #1 auto_rdy = (hold == 0);
  end

  task automatic check1(input string name, input logic [31:0] actual, input logic [31:0] want);
    checks++;
    if (actual !== want) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, actual, want);
    end
  endtask

  task automatic add_term();
`ifdef HEX_STREAM_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`else
    exp_q.push_back(8'h20);
`endif
  endtask

  task automatic exp_word(input logic [31:0] chars);
    for (int i = 3; i >= 0; i--) exp_q.push_back(chars[i*8 +: 8]);
    add_term();
  endtask

  task automatic check_bytes(input string name);
    checks++;
    if (got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s: byte count %0d, required %0d", name, got.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL %s byte %0d: got %h, required %h", name, i, got[i], exp_q[i]);
        end
      end
    end
    got.delete();
    exp_q.delete();
  endtask

  task automatic push_word(input logic [15:0] w);
    @(posedge clk); #1;
    din = w;
    din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || b_busy) && n < max_cyc);
    checks++;
    if (busy || b_busy) begin
      errors++;
      $display("FAIL %s_timeout: busy=%b b_busy=%b after %0d cycles, required 0", name, busy, b_busy, n);
    end
  endtask

  typedef struct {
    logic [15:0] din;
    logic [31:0] chars;
  } vec_t;
  vec_t vecs[6];

  logic [15:0] ow[6];
  int n;

  initial begin
    vecs[0] = '{din: 16'hA5F0, chars: 32'h41354630};
    vecs[1] = '{din: 16'h0000, chars: 32'h30303030};
    vecs[2] = '{din: 16'hFFFF, chars: 32'h46464646};
    vecs[3] = '{din: 16'h09AF, chars: 32'h30394146};
    vecs[4] = '{din: 16'h7E3B, chars: 32'h37453342};
    vecs[5] = '{din: 16'hBEEF, chars: 32'h42454546};
    ow[0] = 16'h1111; ow[1] = 16'h2222; ow[2] = 16'h3333;
    ow[3] = 16'h4444; ow[4] = 16'h5555; ow[5] = 16'h6666;

    // Reset state
    repeat (3) @(negedge clk);
    check1("rst_tstart", tstart, 0);
    check1("rst_tbus", tbus, 8'h00);
    check1("rst_busy", busy, 0);
    check1("rst_ovf", ovf, 0);
    check1("rst_b_busy", b_busy, 0);
    @(posedge clk); #1 rstn = 1'b1;
    @(posedge clk); #1;
    check1("ready_after_rst", din_ready, 1);

    // 8-bit every-word instance: same byte twice prints twice
    @(posedge clk); #1;
    b_din = 8'h9C;
    b_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 b_valid = 1'b0;
    wait_idle("b_9c", 200);
    got = got_b;
    got_b.delete();
    exp_q.push_back(8'h39); exp_q.push_back(8'h43); add_term();
    exp_q.push_back(8'h39); exp_q.push_back(8'h43); add_term();
    check_bytes("b_9c");
    check1("b_ovf", b_ovf, 0);

    // Table of single words with tready held high
    for (int i = 0; i < 6; i++) begin
      push_word(vecs[i].din);
      wait_idle($sformatf("vec%0d", i), 200);
      exp_word(vecs[i].chars);
      check_bytes($sformatf("vec%0d", i));
      check1($sformatf("vec%0d_busy", i), busy, 0);
    end

    // Repeated value is suppressed until it changes
    @(posedge clk); #1;
    din = 16'h1234;
    din_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1 din = 16'h1235;
    @(posedge clk); #1 din_valid = 1'b0;
    wait_idle("onchange", 400);
    exp_word(32'h31323334);
    exp_word(32'h31323335);
    check_bytes("onchange");

    // Overflow with the transmitter stalled; the FSM already holds word 0,
    // so the FIFO fills on word 4 and word 5 is dropped
    tready_man = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 4) check1("ready_before_fill", din_ready, 1);
      if (i == 5) begin
        check1("ready_when_full", din_ready, 0);
        check1("ovf_before_drop", ovf, 0);
      end
      din = ow[i];
      din_valid = 1'b1;
    end
    @(posedge clk); #1 din_valid = 1'b0;
    check1("ovf_after_drop", ovf, 1);
    check1("no_tx_while_stalled", got.size(), 0);
    tready_man = 1'b1;
    wait_idle("overflow", 800);
    for (int i = 0; i < 5; i++) exp_word({4{4'h3, 4'(i + 1)}});
    check_bytes("overflow");
    check1("ovf_sticky", ovf, 1);

    // Slow transmitter: tready low for 20 cycles after each start
    tr_auto = 1'b1;
    push_word(16'h0F1E);
    push_word(16'hC3D2);
    wait_idle("toggle", 2000);
    tr_auto = 1'b0;
    exp_word(32'h30463145);
    exp_word(32'h43334432);
    check_bytes("toggle");

    // Reset in the middle of a word
    push_word(16'hABCD);
    n = 0;
    while (got.size() < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check1("midword_two_chars", got.size(), 2);
    #1 rstn = 1'b0;
    #1;
    check1("midword_rst_tstart", tstart, 0);
    check1("midword_rst_busy", busy, 0);
    check1("midword_rst_ovf", ovf, 0);
    got.delete();
    repeat (5) @(negedge clk);
    @(posedge clk); #1 rstn = 1'b1;
    repeat (20) @(negedge clk);
    check1("no_resume", got.size(), 0);
    check1("no_resume_busy", busy, 0);
    push_word(16'h00FF);
    wait_idle("after_rst", 200);
    exp_word(32'h30304646);
    check_bytes("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion within 1 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
